thread_scheduler: RTL and testbench

Fetch-side thread scheduler for the barrel-threaded RV32 core. It holds one PC and one run-state per hardware thread and picks which thread fetches each cycle. The chosen thread's `tid_f`/`pc_f`/`pc_plus4_f` travel with the instruction into decode and the multithreaded register file. It also applies thread start, halt, park/wake for long-latency stalls, and branch/jump redirects coming back from execute.

---
 rtl/thread_scheduler.sv | 170 +++++++++++++++++
 tb/tb_thread_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_scheduler.sv
// thread_scheduler: per-thread PC and run-state store plus the fetch-thread selector.
// Define THREAD_SCHED_SKIP_EN for skip-mode selection; leave undefined for a strict barrel rotation.
module thread_scheduler #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       NUM_THREADS   = 8,
    parameter int                       BITS_THREADS  = $clog2(NUM_THREADS),
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_f,
    input  logic                     start_valid,
    input  logic [BITS_THREADS-1:0]  start_tid,
    input  logic [ADDRESS_WIDTH-1:0] start_pc,
    input  logic                     halt_valid,
    input  logic [BITS_THREADS-1:0]  halt_tid,
    input  logic                     park_valid,
    input  logic [BITS_THREADS-1:0]  park_tid,
    input  logic                     wake_valid,
    input  logic [BITS_THREADS-1:0]  wake_tid,
    input  logic                     redirect_valid_e,
    input  logic [BITS_THREADS-1:0]  tid_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic                     issue_valid_f,
    output logic [BITS_THREADS-1:0]  tid_f,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
    output logic [NUM_THREADS-1:0]   run_mask,
    output logic [NUM_THREADS-1:0]   active_mask
);

    // Per-thread state
    //   state    | meaning
    //   T_IDLE   | not launched or halted; never fetches, ignores redirects
    //   T_RUN    | eligible for fetch selection
    //   T_PARKED | long-latency op outstanding; keeps its PC, waits for wake
    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_RUN    = 2'd1,
        T_PARKED = 2'd2
    } thread_state_e;

    localparam logic [BITS_THREADS:0] NUM_W = (BITS_THREADS+1)'(NUM_THREADS);

    thread_state_e              state_q [NUM_THREADS];
    thread_state_e              state_d [NUM_THREADS];
    logic [ADDRESS_WIDTH-1:0]   pc_q    [NUM_THREADS];
    logic [ADDRESS_WIDTH-1:0]   pc_d    [NUM_THREADS];
    logic [BITS_THREADS-1:0]    last_tid_q;
    logic [BITS_THREADS-1:0]    last_tid_d;

    logic [BITS_THREADS-1:0]    sel_tid;
    logic                       sel_valid;
    logic                       issue_fire;

    logic [NUM_THREADS-1:0]     halt_hit;
    logic [NUM_THREADS-1:0]     park_hit;
    logic [NUM_THREADS-1:0]     wake_hit;
    logic [NUM_THREADS-1:0]     start_hit;
    logic [NUM_THREADS-1:0]     redir_hit;

    // (base + k) mod NUM_THREADS for k in 1..NUM_THREADS, valid for any thread count
    function automatic logic [BITS_THREADS-1:0] tid_offset(input logic [BITS_THREADS-1:0] base,
                                                            input int k);
        logic [BITS_THREADS:0] sum;
        sum = {1'b0, base} + (BITS_THREADS+1)'(k);
        if (sum >= NUM_W) begin
            sum = sum - NUM_W;
        end
        return sum[BITS_THREADS-1:0];
    endfunction

    always_comb begin
        sel_tid   = tid_offset(last_tid_q, 1);
        sel_valid = 1'b0;
`ifdef THREAD_SCHED_SKIP_EN
        // Walk farthest-to-nearest so the closest RUN thread after last_tid wins
        for (int k = NUM_THREADS; k >= 1; k--) begin
            if (state_q[tid_offset(last_tid_q, k)] == T_RUN) begin
                sel_tid   = tid_offset(last_tid_q, k);
                sel_valid = 1'b1;
            end
        end
`else
        sel_valid = (state_q[sel_tid] == T_RUN);
`endif
    end

    assign issue_fire = sel_valid && !stall_f;

    always_comb begin
`ifdef THREAD_SCHED_SKIP_EN
        last_tid_d = issue_fire ? sel_tid : last_tid_q;
`else
        last_tid_d = stall_f ? last_tid_q : sel_tid;
`endif
    end

    always_comb begin
        halt_hit  = '0;
        park_hit  = '0;
        wake_hit  = '0;
        start_hit = '0;
        redir_hit = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            halt_hit[i]  = halt_valid       && (halt_tid  == BITS_THREADS'(i));
            park_hit[i]  = park_valid       && (park_tid  == BITS_THREADS'(i));
            wake_hit[i]  = wake_valid       && (wake_tid  == BITS_THREADS'(i));
            start_hit[i] = start_valid      && (start_tid == BITS_THREADS'(i));
            redir_hit[i] = redirect_valid_e && (tid_e     == BITS_THREADS'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            state_d[i] = state_q[i];
            pc_d[i]    = pc_q[i];

            if (halt_hit[i]) begin
                state_d[i] = T_IDLE;
            end else if (park_hit[i] && state_q[i] == T_RUN) begin
                state_d[i] = T_PARKED;
            end else if (wake_hit[i] && state_q[i] == T_PARKED) begin
                state_d[i] = T_RUN;
            end else if (start_hit[i] && state_q[i] == T_IDLE) begin
                state_d[i] = T_RUN;
            end

            // A start overruled by a same-cycle halt does not load its PC either
            if (start_hit[i] && state_q[i] == T_IDLE && !halt_hit[i]) begin
                pc_d[i] = start_pc;
            end else if (redir_hit[i] && state_q[i] != T_IDLE) begin
                pc_d[i] = pc_target_e;
            end else if (issue_fire && sel_tid == BITS_THREADS'(i)) begin
                pc_d[i] = pc_q[i] + ADDRESS_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                state_q[i] <= (i == 0) ? T_RUN : T_IDLE;
                pc_q[i]    <= RESET_PC;
            end
            last_tid_q <= BITS_THREADS'(NUM_THREADS - 1);
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                state_q[i] <= state_d[i];
                pc_q[i]    <= pc_d[i];
            end
            last_tid_q <= last_tid_d;
        end
    end

    assign issue_valid_f = sel_valid;
    assign tid_f         = sel_tid;
    assign pc_f          = pc_q[sel_tid];
    assign pc_plus4_f    = pc_q[sel_tid] + ADDRESS_WIDTH'(4);

    always_comb begin
        run_mask    = '0;
        active_mask = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            run_mask[i]    = (state_q[i] == T_RUN);
            active_mask[i] = (state_q[i] != T_IDLE);
        end
    end

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler with five threads (non-power-of-two rotation).
// A spec-level model predicts every output each cycle; literal expectations pin key points.
module tb_thread_scheduler;
    localparam int N  = 5;
    localparam int BT = 3;
    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PARKED = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, stall_f;
    logic          start_valid, halt_valid, park_valid, wake_valid, redirect_valid_e;
    logic [BT-1:0] start_tid, halt_tid, park_tid, wake_tid, tid_e;
    logic [31:0]   start_pc, pc_target_e;
    logic          issue_valid_f;
    logic [BT-1:0] tid_f;
    logic [31:0]   pc_f, pc_plus4_f;
    logic [N-1:0]  run_mask, active_mask;

    thread_scheduler #(
        .ADDRESS_WIDTH(32), .NUM_THREADS(N), .BITS_THREADS(BT), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .stall_f(stall_f),
        .start_valid(start_valid), .start_tid(start_tid), .start_pc(start_pc),
        .halt_valid(halt_valid), .halt_tid(halt_tid),
        .park_valid(park_valid), .park_tid(park_tid),
        .wake_valid(wake_valid), .wake_tid(wake_tid),
        .redirect_valid_e(redirect_valid_e), .tid_e(tid_e), .pc_target_e(pc_target_e),
        .issue_valid_f(issue_valid_f), .tid_f(tid_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
        .run_mask(run_mask), .active_mask(active_mask)
    );

    int          checks   = 0;
    int          failures = 0;
    int          m_state [N];
    logic [31:0] m_pc    [N];
    int          m_last;
    bit          m_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void m_select(output bit v, output int t);
`ifdef THREAD_SCHED_SKIP_EN
        v = 1'b0;
        t = (m_last + 1) % N;
        for (int k = 1; k <= N; k++) begin
            if (!v && m_state[(m_last + k) % N] == S_RUN) begin
                v = 1'b1;
                t = (m_last + k) % N;
            end
        end
`else
        t = (m_last + 1) % N;
        v = (m_state[t] == S_RUN);
`endif
    endfunction

    task automatic check_outputs();
        bit v;
        int t;
        logic [N-1:0] rm, am;
        m_select(v, t);
        rm = '0;
        am = '0;
        for (int i = 0; i < N; i++) begin
            rm[i] = (m_state[i] == S_RUN);
            am[i] = (m_state[i] != S_IDLE);
        end
        chk("issue_valid_f", 32'(issue_valid_f), 32'(v));
        chk("tid_f",         32'(tid_f),         32'(t));
        chk("pc_f",          pc_f,               m_pc[t]);
        chk("pc_plus4_f",    pc_plus4_f,         m_pc[t] + 32'd4);
        chk("run_mask",      32'(run_mask),      32'(rm));
        chk("active_mask",   32'(active_mask),   32'(am));
    endtask

    task automatic model_step();
        bit v, fire, h, p, w, s, r;
        int t;
        int ns [N];
        logic [31:0] np [N];
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_state[i] = (i == 0) ? S_RUN : S_IDLE;
                m_pc[i]    = 32'h0;
            end
            m_last = N - 1;
            m_ok   = 1'b1;
            return;
        end
        if (!m_ok) return;
        m_select(v, t);
        fire = v && !stall_f;
        for (int i = 0; i < N; i++) begin
            h = halt_valid       && int'(halt_tid)  == i;
            p = park_valid       && int'(park_tid)  == i;
            w = wake_valid       && int'(wake_tid)  == i;
            s = start_valid      && int'(start_tid) == i;
            r = redirect_valid_e && int'(tid_e)     == i;
            ns[i] = m_state[i];
            np[i] = m_pc[i];
            if (h)                               ns[i] = S_IDLE;
            else if (p && m_state[i] == S_RUN)    ns[i] = S_PARKED;
            else if (w && m_state[i] == S_PARKED) ns[i] = S_RUN;
            else if (s && m_state[i] == S_IDLE)   ns[i] = S_RUN;
            if (s && m_state[i] == S_IDLE && !h)  np[i] = start_pc;
            else if (r && m_state[i] != S_IDLE)   np[i] = pc_target_e;
            else if (fire && t == i)              np[i] = m_pc[i] + 32'd4;
        end
        for (int i = 0; i < N; i++) begin
            m_state[i] = ns[i];
            m_pc[i]    = np[i];
        end
`ifdef THREAD_SCHED_SKIP_EN
        if (fire) m_last = t;
`else
        if (!stall_f) m_last = t;
`endif
    endtask

    task automatic clear_in();
        rst = 1'b0; stall_f = 1'b0;
        start_valid = 1'b0; start_tid = '0; start_pc = '0;
        halt_valid = 1'b0; halt_tid = '0;
        park_valid = 1'b0; park_tid = '0;
        wake_valid = 1'b0; wake_tid = '0;
        redirect_valid_e = 1'b0; tid_e = '0; pc_target_e = '0;
    endtask

    // Inputs are set by the caller just after a falling edge; one rising edge consumes them.
    task automatic cycle();
        if (m_ok) check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
        clear_in();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_slot(input int tid);
        bit v, ok;
        int t;
        ok = 1'b0;
        for (int n = 0; n < 25; n++) begin
            m_select(v, t);
            if (v && t == tid) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_slot actual=no_issue required=issue_of_tid_%0d", tid);
        end
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        @(negedge clk);
        cycle();
        rst = 1'b1;
        cycle();

        chk("rst_issue_valid", 32'(issue_valid_f), 32'd1);
        chk("rst_tid",         32'(tid_f),         32'd0);
        chk("rst_pc",          pc_f,               32'h0);
        chk("rst_pc_plus4",    pc_plus4_f,         32'h4);
        chk("rst_run_mask",    32'(run_mask),      32'd1);
        chk("rst_active_mask", 32'(active_mask),   32'd1);

        run(3);
`ifdef THREAD_SCHED_SKIP_EN
        chk("solo_tid", 32'(tid_f), 32'd0);
        chk("solo_pc",  pc_f,       32'hC);
`else
        chk("barrel_tid",   32'(tid_f),         32'd3);
        chk("barrel_valid", 32'(issue_valid_f), 32'd0);
`endif

        start_valid = 1'b1; start_tid = 3'd1; start_pc = 32'h100;
        cycle();
        start_valid = 1'b1; start_tid = 3'd2; start_pc = 32'h200;
        cycle();
        run(10);

        // park thread 1 on its issue cycle, wake 5 cycles later
        wait_slot(1);
        park_valid = 1'b1; park_tid = 3'd1;
        cycle();
        run(4);
        wake_valid = 1'b1; wake_tid = 3'd1;
        cycle();
        run(8);

        // redirect thread 0 while it issues
        wait_slot(0);
        redirect_valid_e = 1'b1; tid_e = 3'd0; pc_target_e = 32'h40;
        cycle();
        wait_slot(0);
        chk("redirect_pc", pc_f, 32'h40);

        start_valid = 1'b1; start_tid = 3'd3; start_pc = 32'h300;
        cycle();
        start_valid = 1'b1; start_tid = 3'd4; start_pc = 32'h400;
        cycle();
        run(8);

        // three-cycle stall with a halt of thread 4 arriving inside it
        wait_slot(3);
        stall_f = 1'b1; halt_valid = 1'b1; halt_tid = 3'd4;
        cycle();
        stall_f = 1'b1;
        cycle();
        stall_f = 1'b1;
        cycle();
        chk("halt_in_stall_active4", 32'(active_mask[4]), 32'd0);
        run(6);

        // same-thread conflicts and ignored events
        halt_valid = 1'b1; halt_tid = 3'd2; park_valid = 1'b1; park_tid = 3'd2;
        wake_valid = 1'b1; wake_tid = 3'd1;
        cycle();
        start_valid = 1'b1; start_tid = 3'd2; start_pc = 32'h500;
        redirect_valid_e = 1'b1; tid_e = 3'd2; pc_target_e = 32'h999;
        cycle();
        redirect_valid_e = 1'b1; tid_e = 3'd4; pc_target_e = 32'h777;
        cycle();
        wait_slot(2);
        chk("start_beats_redirect", pc_f, 32'h500);
        run(4);

        // PC wraps modulo 2^32
        redirect_valid_e = 1'b1; tid_e = 3'd1; pc_target_e = 32'hFFFF_FFFC;
        cycle();
        wait_slot(1);
        cycle();
        wait_slot(1);
        chk("pc_wrap", pc_f, 32'h0);

        // reset overrides events at the same edge
        rst = 1'b1;
        halt_valid = 1'b1; halt_tid = 3'd0;
        redirect_valid_e = 1'b1; tid_e = 3'd0; pc_target_e = 32'h123;
        start_valid = 1'b1; start_tid = 3'd3; start_pc = 32'h888;
        cycle();
        chk("midrst_tid",         32'(tid_f),       32'd0);
        chk("midrst_pc",          pc_f,             32'h0);
        chk("midrst_run_mask",    32'(run_mask),    32'd1);
        chk("midrst_active_mask", 32'(active_mask), 32'd1);
        run(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
